ps2_host_tx: RTL and testbench

- Host-to-device PS/2 transmitter: the sending end of the keyboard link, opposite to the scancode receive path that feeds the keypad emulation.
- Sends one command byte per request to the keyboard, e.g. 0xED plus an LED mask, or 0xFF reset.
- Drives the open-drain PS/2 clock and data lines through release-high outputs. Output 1 = release (tri-state at top level); output 0 = drive low.
- Sits in the clk_sys domain beside the controller's PS/2 port.

---
 rtl/ps2_host_tx.sv | 167 ++++++++++++++++
 tb/tb_ps2_host_tx.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
`default_nettype none
// ============================================================================
// Module   : ps2_host_tx
// Purpose  : PS/2 host-to-device byte transmitter over open-drain clk/data.
// Revision : 1.0
// ============================================================================
module ps2_host_tx #(
  parameter int CLK_FREQ_KHZ = 21477,
  parameter int INHIBIT_US   = 100,
  parameter int TIMEOUT_MS   = 15
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_i,
  input  logic       ps2_dat_i,
  output logic       ps2_clk_o,
  output logic       ps2_dat_o,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam int INH_CYC = CLK_FREQ_KHZ * INHIBIT_US / 1000;
  localparam int TO_CYC  = CLK_FREQ_KHZ * TIMEOUT_MS;
  localparam int INH_W   = $clog2(INH_CYC + 1);
  localparam int TO_W    = $clog2(TO_CYC + 1);

  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INH_CYC - 1);
  localparam logic [TO_W-1:0]  TO_LIM   = TO_W'(TO_CYC);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_INHIBIT   = 3'd1;
  localparam logic [2:0] S_RTS       = 3'd2;
  localparam logic [2:0] S_SHIFT     = 3'd3;
  localparam logic [2:0] S_WAIT_IDLE = 3'd4;

  logic [2:0]       state_q, state_d;
  logic             clk_s1_q, clk_s2_q, clk_prev_q;
  logic             dat_s1_q, dat_s2_q;
  logic [9:0]       shift_q, shift_d;
  logic [3:0]       bitcnt_q, bitcnt_d;
  logic             dat_q, dat_d;
  logic [INH_W-1:0] inh_q, inh_d;
  logic [TO_W-1:0]  to_q, to_d;

  logic fall_edge;
  logic accept;
  logic in_xfer;
  logic timeout_hit;
  logic ack_sample;
  logic line_idle;

  // Lines idle high, so the synchronizers and edge history reset to 1.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      clk_prev_q <= 1'b1;
      dat_s1_q   <= 1'b1;
      dat_s2_q   <= 1'b1;
    end else begin
      clk_s1_q   <= ps2_clk_i;
      clk_s2_q   <= clk_s1_q;
      clk_prev_q <= clk_s2_q;
      dat_s1_q   <= ps2_dat_i;
      dat_s2_q   <= dat_s1_q;
    end
  end

  assign fall_edge   = clk_prev_q & ~clk_s2_q;
  assign accept      = (state_q == S_IDLE) & tx_valid;
  assign in_xfer     = (state_q == S_RTS) | (state_q == S_SHIFT) | (state_q == S_WAIT_IDLE);
  assign timeout_hit = in_xfer & (to_q == TO_LIM);
  assign ack_sample  = (state_q == S_SHIFT) & fall_edge & (bitcnt_q == 4'd10);
  assign line_idle   = clk_s2_q & dat_s2_q;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) state_d = S_INHIBIT;
      end
      S_INHIBIT: begin
        if (inh_q == INH_LAST) state_d = S_RTS;
      end
      S_RTS: begin
        state_d = timeout_hit ? S_IDLE : S_SHIFT;
      end
      S_SHIFT: begin
        if (timeout_hit)     state_d = S_IDLE;
        else if (ack_sample) state_d = dat_s2_q ? S_IDLE : S_WAIT_IDLE;
      end
      S_WAIT_IDLE: begin
        if (timeout_hit || line_idle) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Pulses are Mealy on the exit cycle so they precede tx_ready by one cycle.
  always_comb begin
    tx_ready  = (state_q == S_IDLE);
    busy      = (state_q != S_IDLE);
    ps2_clk_o = (state_q != S_INHIBIT);
    ps2_dat_o = 1'b1;
    if (state_q == S_RTS)        ps2_dat_o = 1'b0;
    else if (state_q == S_SHIFT) ps2_dat_o = dat_q;
    error = timeout_hit | (ack_sample & dat_s2_q);
    done  = (state_q == S_WAIT_IDLE) & line_idle & ~timeout_hit;
  end

  always_comb begin
    shift_d  = shift_q;
    bitcnt_d = bitcnt_q;
    dat_d    = dat_q;
    inh_d    = (state_q == S_INHIBIT) ? inh_q + INH_W'(1) : '0;
    to_d     = (in_xfer && !timeout_hit) ? to_q + TO_W'(1) : '0;
    case (state_q)
      S_IDLE: begin
        dat_d    = 1'b1;
        bitcnt_d = 4'd0;
        if (accept) shift_d = {1'b1, ~^tx_data, tx_data};
      end
      S_RTS: begin
        dat_d    = 1'b0;
        bitcnt_d = 4'd0;
      end
      S_SHIFT: begin
        if (fall_edge && bitcnt_q < 4'd10) begin
          dat_d    = shift_q[0];
          shift_d  = {1'b0, shift_q[9:1]};
          bitcnt_d = bitcnt_q + 4'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      shift_q  <= '0;
      bitcnt_q <= '0;
      dat_q    <= 1'b1;
      inh_q    <= '0;
      to_q     <= '0;
    end else begin
      shift_q  <= shift_d;
      bitcnt_q <= bitcnt_d;
      dat_q    <= dat_d;
      inh_q    <= inh_d;
      to_q     <= to_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ps2_host_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_ps2_host_tx
// Purpose  : Self-checking bench with a behavioural PS/2 device model.
// Revision : 1.0
// ============================================================================
module tb_ps2_host_tx;

  localparam int INH_CYC = 2147;
  localparam int TO_CYC  = 21477;
  localparam int HALF    = 10;

  logic       clk_sys = 1'b0;
  logic       reset   = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, ps2_clk_o, ps2_dat_o, busy, done, error;
  logic       dev_clk = 1'b1;
  logic       dev_dat = 1'b1;
  wire        clk_line = ps2_clk_o & dev_clk;
  wire        dat_line = ps2_dat_o & dev_dat;

  int n_checks = 0;
  int n_pass   = 0;
  int done_cnt = 0;
  int err_cnt  = 0;
  bit pulse_prev = 1'b0;

  typedef struct {
    logic [7:0] data;
    bit         ack;
    bit         exp_par;
  } vec_t;
  vec_t vecs[5];

  ps2_host_tx #(.CLK_FREQ_KHZ(21477), .INHIBIT_US(100), .TIMEOUT_MS(1)) dut (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .ps2_clk_i(clk_line),
    .ps2_dat_i(dat_line),
    .ps2_clk_o(ps2_clk_o),
    .ps2_dat_o(ps2_dat_o),
    .busy     (busy),
    .done     (done),
    .error    (error)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Odd parity from a plain count of ones.
  function automatic bit ref_parity(input logic [7:0] b);
    return ($countones(b) % 2) == 0;
  endfunction

  always @(negedge clk_sys) begin
    if (done)  done_cnt++;
    if (error) err_cnt++;
    if (pulse_prev) check("ready_after_pulse", tx_ready, 1);
    if (done || error) check("pulse_exclusive", done & error, 0);
    pulse_prev = done | error;
  end

  task automatic request(input logic [7:0] b);
    int n = 0;
    while (!tx_ready && n < 200) begin @(negedge clk_sys); n++; end
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clk_sys);
    tx_valid = 1'b0;
  endtask

  task automatic wait_inhibit();
    int n = 0;
    int len = 0;
    while (ps2_clk_o && n < 100) begin @(negedge clk_sys); n++; end
    while (!ps2_clk_o && len < 5000) begin @(negedge clk_sys); len++; end
    check("inhibit_len", len, INH_CYC);
    check("start_bit", ps2_dat_o, 0);
  endtask

  task automatic dev_bit(output logic s);
    dev_clk = 1'b0;
    repeat (HALF) @(negedge clk_sys);
    s = dat_line;
    dev_clk = 1'b1;
    repeat (HALF) @(negedge clk_sys);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit ack, input bit poke, input bit exp_par);
    logic [10:1] bits;
    logic s;
    int d0, e0, n;
    d0 = done_cnt;
    e0 = err_cnt;
    request(b);
    wait_inhibit();
    repeat (5) @(negedge clk_sys);
    for (int i = 1; i <= 10; i++) begin
      if (poke && i == 3) begin tx_data = 8'h55; tx_valid = 1'b1; end
      if (poke && i == 8) begin tx_valid = 1'b0; tx_data = b; end
      dev_bit(s);
      bits[i] = s;
    end
    check("data_bits", bits[8:1], b);
    check("parity_bit", bits[9], exp_par);
    check("stop_bit", bits[10], 1);
    if (ack) dev_dat = 1'b0;
    repeat (HALF) @(negedge clk_sys);
    dev_bit(s);
    dev_dat = 1'b1;
    n = 0;
    while (!tx_ready && n < 100) begin @(negedge clk_sys); n++; end
    check("ready_return", tx_ready, 1);
    repeat (3) @(negedge clk_sys);
    check("done_pulses", done_cnt - d0, ack ? 1 : 0);
    check("error_pulses", err_cnt - e0, ack ? 0 : 1);
    check("lines_released", {ps2_clk_o, ps2_dat_o}, 2'b11);
    if (poke) begin
      repeat (20) @(negedge clk_sys);
      check("no_accept_while_busy", {busy, ps2_clk_o}, 2'b01);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1);
  end

  initial begin
    logic [7:0] b;
    logic s;
    int n, d0;

    vecs[0] = '{8'hED, 1'b1, 1'b1};
    vecs[1] = '{8'h00, 1'b1, 1'b1};
    vecs[2] = '{8'hFF, 1'b1, 1'b1};
    vecs[3] = '{8'h01, 1'b1, 1'b0};
    vecs[4] = '{8'h3C, 1'b0, 1'b1};

    repeat (3) @(negedge clk_sys);
    check("rst_lines", {ps2_clk_o, ps2_dat_o}, 2'b11);
    check("rst_ready_busy", {tx_ready, busy}, 2'b10);
    check("rst_pulses", {done, error}, 2'b00);
    reset = 1'b0;
    repeat (3) @(negedge clk_sys);

    for (int i = 0; i < 5; i++)
      send_byte(vecs[i].data, vecs[i].ack, 1'b0, vecs[i].exp_par);

    for (int i = 0; i < 4; i++) begin
      b = 8'($urandom);
      send_byte(b, 1'b1, 1'b0, ref_parity(b));
    end

    send_byte(8'h9C, 1'b1, 1'b1, 1'b1);

    // Device never clocks: the transfer must time out from RTS entry.
    d0 = done_cnt;
    request(8'h12);
    wait_inhibit();
    n = 0;
    while (!error && n < TO_CYC + 200) begin @(negedge clk_sys); n++; end
    check("timeout_cycles", n, TO_CYC);
    @(negedge clk_sys);
    check("timeout_release", {ps2_clk_o, ps2_dat_o, tx_ready}, 3'b111);
    check("timeout_no_done", done_cnt - d0, 0);

    // Reset while the device holds clock low after its 4th fall.
    request(8'hE6);
    wait_inhibit();
    repeat (5) @(negedge clk_sys);
    for (int i = 0; i < 3; i++) dev_bit(s);
    dev_clk = 1'b0;
    repeat (HALF) @(negedge clk_sys);
    check("pre_reset_d3", ps2_dat_o, 0);
    #2 reset = 1'b1;
    #1;
    check("reset_release", {ps2_clk_o, ps2_dat_o}, 2'b11);
    check("reset_idle", {tx_ready, busy}, 2'b10);
    @(negedge clk_sys);
    dev_clk = 1'b1;
    reset = 1'b0;
    repeat (5) @(negedge clk_sys);
    send_byte(8'hF4, 1'b1, 1'b0, ref_parity(8'hF4));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
